// File: rtl/sftb_pkg.sv
// Shared types and constants for the stereo frame scheduler.
package sftb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  localparam logic CHANNEL_LEFT  = 1'b0;
  localparam logic CHANNEL_RIGHT = 1'b1;

  localparam int unsigned UNDERRUN_COUNT_WIDTH = 16;

endpackage

// File: rtl/stereo_pair_fifo.sv
// Synchronous FIFO of packed {left,right} stereo pairs; DEPTH must be a power of two.
module stereo_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned LEVEL_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
        level <= level + LEVEL_WIDTH'(1);
      end else if (pop && !push) begin
        level <= level - LEVEL_WIDTH'(1);
      end
    end
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (level == LEVEL_WIDTH'(DEPTH));
  assign empty_c = (level == '0);

endmodule

// File: rtl/stereo_frame_scheduler.sv
// Paces stereo frames from a prefetch FIFO onto a left/right multiplexed output bus.
// SFTB_MUTE_ON_UNDERRUN_EN: underrun frames output zeros instead of repeating the last pair.
module stereo_frame_scheduler
  import sftb_pkg::*;
#(
  parameter int unsigned CLOCK_DIV    = 256,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SAMPLE_WIDTH = 32
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              enable,
  output logic                              src_req,
  input  logic                              src_ack,
  input  logic signed [SAMPLE_WIDTH-1:0]    src_left,
  input  logic signed [SAMPLE_WIDTH-1:0]    src_right,
  output logic signed [SAMPLE_WIDTH-1:0]    out_sample,
  output logic                              out_channel,
  output logic                              out_valid,
  output logic                              underrun,
  output logic [UNDERRUN_COUNT_WIDTH-1:0]   underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int unsigned CNT_WIDTH  = $clog2(CLOCK_DIV);
  localparam int unsigned PAIR_WIDTH = 2 * SAMPLE_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLOCK_DIV - 1);
  localparam logic [UNDERRUN_COUNT_WIDTH-1:0] COUNT_MAX = '1;

  fetch_state_e                   fetch_state;
  logic [CNT_WIDTH-1:0]           frame_cnt;
  logic                           right_pending;
  logic signed [SAMPLE_WIDTH-1:0] right_hold;

  logic [PAIR_WIDTH-1:0]          fifo_head_c;
  logic signed [SAMPLE_WIDTH-1:0] head_left_c;
  logic signed [SAMPLE_WIDTH-1:0] head_right_c;
  logic signed [SAMPLE_WIDTH-1:0] sub_left_c;
  logic signed [SAMPLE_WIDTH-1:0] sub_right_c;
  logic                           fifo_full_c;
  logic                           fifo_empty_c;
  logic                           push_c;
  logic                           pop_c;
  logic                           strobe_c;

  assign push_c       = (fetch_state == REQ) && src_ack;
  assign strobe_c     = enable && (frame_cnt == CNT_LAST);
  assign pop_c        = strobe_c && !fifo_empty_c;
  assign head_left_c  = fifo_head_c[PAIR_WIDTH-1:SAMPLE_WIDTH];
  assign head_right_c = fifo_head_c[SAMPLE_WIDTH-1:0];

  stereo_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data ({src_left, src_right}),
    .pop       (pop_c),
    .head_c    (fifo_head_c),
    .level     (fifo_level),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Fetch FSM: request only when there is room, so a push never meets a full FIFO.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_state <= IDLE;
      src_req     <= 1'b0;
    end else begin
      case (fetch_state)
        IDLE: begin
          if (!fifo_full_c) begin
            fetch_state <= REQ;
            src_req     <= 1'b1;
          end
        end
        REQ: begin
          if (src_ack) begin
            fetch_state <= IDLE;
            src_req     <= 1'b0;
          end
        end
        default: begin
          fetch_state <= IDLE;
          src_req     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      frame_cnt <= CNT_LAST;
    end else if (frame_cnt == CNT_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef SFTB_MUTE_ON_UNDERRUN_EN
  assign sub_left_c  = '0;
  assign sub_right_c = '0;
`else
  logic signed [SAMPLE_WIDTH-1:0] last_left;
  logic signed [SAMPLE_WIDTH-1:0] last_right;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (pop_c) begin
      last_left  <= head_left_c;
      last_right <= head_right_c;
    end
  end

  assign sub_left_c  = last_left;
  assign sub_right_c = last_right;
`endif

  // Right half is latched at the strobe so it completes even if enable drops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_sample     <= '0;
      out_channel    <= CHANNEL_LEFT;
      out_valid      <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      right_pending  <= 1'b0;
      right_hold     <= '0;
    end else begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      if (strobe_c) begin
        out_valid     <= 1'b1;
        out_channel   <= CHANNEL_LEFT;
        right_pending <= 1'b1;
        if (fifo_empty_c) begin
          out_sample <= sub_left_c;
          right_hold <= sub_right_c;
          underrun   <= 1'b1;
          if (underrun_count != COUNT_MAX) begin
            underrun_count <= underrun_count + UNDERRUN_COUNT_WIDTH'(1);
          end
        end else begin
          out_sample <= head_left_c;
          right_hold <= head_right_c;
        end
      end else if (right_pending) begin
        out_valid     <= 1'b1;
        out_channel   <= CHANNEL_RIGHT;
        out_sample    <= right_hold;
        right_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Directed bench for stereo_frame_scheduler with CLOCK_DIV=8, FIFO_DEPTH=4.
module tb_stereo_frame_scheduler;

  localparam int unsigned CLOCK_DIV    = 8;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned SAMPLE_WIDTH = 32;

`ifdef SFTB_MUTE_ON_UNDERRUN_EN
  localparam int SUB_L = 0;
  localparam int SUB_R = 0;
`else
  localparam int SUB_L = 7;
  localparam int SUB_R = -7;
`endif

  logic                           clock = 1'b0;
  logic                           reset_n;
  logic                           enable;
  logic                           src_req;
  logic                           src_ack;
  logic signed [SAMPLE_WIDTH-1:0] src_left;
  logic signed [SAMPLE_WIDTH-1:0] src_right;
  logic signed [SAMPLE_WIDTH-1:0] out_sample;
  logic                           out_channel;
  logic                           out_valid;
  logic                           underrun;
  logic [15:0]                    underrun_count;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level;

  int checks     = 0;
  int failures   = 0;
  int valid_seen = 0;
  int req_cycles = 0;
  int next_val   = 1;
  bit auto_src   = 1'b0;

  stereo_frame_scheduler #(
    .CLOCK_DIV    (CLOCK_DIV),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .src_req        (src_req),
    .src_ack        (src_ack),
    .src_left       (src_left),
    .src_right      (src_right),
    .out_sample     (out_sample),
    .out_channel    (out_channel),
    .out_valid      (out_valid),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .fifo_level     (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic ch, input int sample);
    check_eq({tag, "_valid"}, out_valid, valid);
    check_eq({tag, "_chan"}, out_channel, ch);
    check_eq({tag, "_sample"}, out_sample, sample);
  endtask

  // One clock: source model acts on the falling edge, outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(negedge clock);
    if (!auto_src) begin
      req_cycles = 0;
    end else if (src_ack) begin
      src_ack    = 1'b0;
      req_cycles = 0;
    end else if (src_req) begin
      req_cycles++;
      if (req_cycles == 2) begin
        src_ack   = 1'b1;
        src_left  = next_val;
        src_right = -next_val;
        next_val++;
      end
    end
    @(posedge clock);
    #1;
    if (out_valid) valid_seen++;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_src_req"}, src_req, 0);
    check_eq({tag, "_level"}, fifo_level, 0);
    check_eq({tag, "_ur"}, underrun, 0);
    check_eq({tag, "_ur_count"}, underrun_count, 0);
    check_out(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    src_ack   = 1'b0;
    src_left  = '0;
    src_right = '0;
    repeat (3) tick();
    check_reset_state("rst");

    // Prefill with pacing disabled
    reset_n    = 1'b1;
    auto_src   = 1'b1;
    valid_seen = 0;
    repeat (40) tick();
    check_eq("prefill_level", fifo_level, 4);
    check_eq("prefill_req", src_req, 0);
    check_eq("prefill_no_valid", valid_seen, 0);

    // Steady state: first strobe on the first enabled edge
    enable = 1'b1;
    tick();
    check_out("ss_left1", 1'b1, 1'b0, 1);
    tick();
    check_out("ss_right1", 1'b1, 1'b1, -1);
    tick();
    check_eq("ss_gap_valid", out_valid, 0);
    repeat (5) tick();
    check_eq("ss_refill_level", fifo_level, 4);
    tick();
    check_out("ss_left2", 1'b1, 1'b0, 2);
    enable = 1'b0;
    tick();
    check_out("ss_right2", 1'b1, 1'b1, -2);
    valid_seen = 0;
    repeat (20) tick();
    check_eq("disable_no_valid", valid_seen, 0);
    check_eq("disable_level", fifo_level, 4);

    // Simultaneous push and pop with two pairs buffered
    auto_src = 1'b0;
    enable   = 1'b1;
    tick();
    check_out("pp_left3", 1'b1, 1'b0, 3);
    repeat (8) tick();
    check_out("pp_left4", 1'b1, 1'b0, 4);
    repeat (7) tick();
    check_eq("pp_pre_level", fifo_level, 2);
    check_eq("pp_pre_req", src_req, 1);
    src_ack   = 1'b1;
    src_left  = 7;
    src_right = -7;
    tick();
    src_ack = 1'b0;
    check_eq("pp_level", fifo_level, 2);
    check_out("pp_left5", 1'b1, 1'b0, 5);
    tick();
    check_out("pp_right5", 1'b1, 1'b1, -5);
    repeat (7) tick();
    check_out("pp_left6", 1'b1, 1'b0, 6);
    repeat (8) tick();
    check_out("pp_left7", 1'b1, 1'b0, 7);
    enable = 1'b0;
    tick();
    check_out("pp_right7", 1'b1, 1'b1, -7);
    check_eq("pp_drained", fifo_level, 0);

    // Underrun: source stalls, three frames
    enable = 1'b1;
    tick();
    check_eq("ur1_pulse", underrun, 1);
    check_eq("ur1_count", underrun_count, 1);
    check_out("ur1_left", 1'b1, 1'b0, SUB_L);
    tick();
    check_eq("ur1_pulse_end", underrun, 0);
    check_out("ur1_right", 1'b1, 1'b1, SUB_R);
    repeat (7) tick();
    check_eq("ur2_pulse", underrun, 1);
    check_eq("ur2_count", underrun_count, 2);
    repeat (8) tick();
    check_eq("ur3_pulse", underrun, 1);
    check_eq("ur3_count", underrun_count, 3);
    enable = 1'b0;
    tick();
    check_eq("ur_final_pulse", underrun, 0);
    check_eq("ur_final_count", underrun_count, 3);

    // Saturation: preload near the top, then keep underrunning
    force dut.underrun_count = 16'hFFFD;
    tick();
    release dut.underrun_count;
    tick();
    check_eq("sat_preload", underrun_count, 32'h0000_FFFD);
    enable = 1'b1;
    tick();
    check_eq("sat_count1", underrun_count, 32'h0000_FFFE);
    repeat (8) tick();
    check_eq("sat_count2", underrun_count, 32'h0000_FFFF);
    repeat (8) tick();
    check_eq("sat_pulse3", underrun, 1);
    check_eq("sat_count3", underrun_count, 32'h0000_FFFF);
    enable = 1'b0;
    tick();

    // Reset in the middle of a handshake with data buffered
    check_eq("mh_req", src_req, 1);
    src_ack   = 1'b1;
    src_left  = 9;
    src_right = -9;
    tick();
    src_ack = 1'b0;
    check_eq("mh_level", fifo_level, 1);
    tick();
    tick();
    check_eq("mh_req2", src_req, 1);
    reset_n = 1'b0;
    tick();
    check_reset_state("mh_rst");

    // First frame after reset underruns with a zero substitute pair
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();
    check_eq("post_rst_pulse", underrun, 1);
    check_out("post_rst_left", 1'b1, 1'b0, 0);
    tick();
    check_out("post_rst_right", 1'b1, 1'b1, 0);
    enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
